// File: rtl/memory_arbiter_if.sv
// Bundle of CPU request/response, shared RAM port and status signals
// for memory_arbiter. The slave modport is the arbiter's view; master
// is the surrounding system (CPU requesters plus RAM).
interface memory_arbiter_if;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic [31:0] iload;
    logic        dhit;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;
    logic        halted;
    logic        err;

    modport slave (
        input  halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
               halted, err
    );

    modport master (
        output halt, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore,
               halted, err
    );
endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates one shared RAM port between instruction fetch and data
// access. Data wins ties; each access has a bounded wait and aborts
// with a sticky error; halt is honoured only between accesses.
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic            CLK,
    input logic            RST,
    memory_arbiter_if.slave bus
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DACC, IACC, HALTED} state_t;

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     lat_addr;
    logic [31:0]     lat_store;
    logic            lat_write;
    logic            halt_seen;
    logic            err_q;
    logic            access;
    logic            timed_out;
    logic            done;

    // Access completion: either RAM answers or the wait budget is spent.
    always_comb begin
        access    = (state == DACC) || (state == IACC);
        timed_out = access && !bus.ram_ready && (wait_cnt == CW'(TIMEOUT));
        done      = access && (bus.ram_ready || timed_out);
    end

    // State machine: grant, latch request, count waits, finish or abort.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_store <= '0;
            lat_write <= 1'b0;
            halt_seen <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt  <= '0;
                    halt_seen <= 1'b0;
                    if (bus.halt) begin
                        state <= HALTED;
                    end else if (bus.dREN || bus.dWEN) begin
                        state     <= DACC;
                        lat_addr  <= bus.daddr;
                        lat_store <= bus.dstore;
                        lat_write <= bus.dWEN;
                    end else if (bus.iREN) begin
                        state     <= IACC;
                        lat_addr  <= bus.iaddr;
                        lat_store <= '0;
                        lat_write <= 1'b0;
                    end
                end
                DACC, IACC: begin
                    // A halt seen at any point of the access is remembered
                    // so the access runs to completion before stopping.
                    if (done) begin
                        if (timed_out) begin
                            err_q <= 1'b1;
                        end
                        state <= (bus.halt || halt_seen) ? HALTED : IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                        if (bus.halt) begin
                            halt_seen <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from the state and the latched request.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.iload    = '0;
        bus.dhit     = 1'b0;
        bus.dload    = '0;
        bus.halted   = 1'b0;
        bus.err      = err_q;
        case (state)
            DACC: begin
                bus.ramaddr  = lat_addr;
                bus.ramstore = lat_store;
                bus.ramWEN   = lat_write;
                bus.ramREN   = !lat_write;
                bus.dhit     = bus.ram_ready;
                bus.dload    = bus.ram_ready ? bus.ramload : '0;
            end
            IACC: begin
                bus.ramaddr  = lat_addr;
                bus.ramREN   = 1'b1;
                bus.ihit     = bus.ram_ready;
                bus.iload    = bus.ram_ready ? bus.ramload : '0;
            end
            HALTED: begin
                bus.halted   = 1'b1;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction model.
module tb_memory_arbiter;
    localparam int unsigned TO = 15;

    logic CLK;
    logic RST;
    int   n_vec;
    int   n_err;

    memory_arbiter_if bus ();

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Transaction-level model: one outstanding access or none.
    bit          m_busy;
    bit          m_data;
    logic [31:0] m_addr;
    logic [31:0] m_store;
    bit          m_write;
    int          m_waited;
    bit          m_halt_flag;
    bit          m_halted;
    bit          m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_data = 0; m_addr = '0; m_store = '0; m_write = 0;
        m_waited = 0; m_halt_flag = 0; m_halted = 0; m_err = 0;
    endtask

    // Compare against the model mid-cycle, then advance DUT and model.
    task automatic tick();
        logic        e_ren, e_wen, hit;
        logic [31:0] e_addr, e_store;
        #2;
        e_ren   = m_busy && !(m_data && m_write);
        e_wen   = m_busy && m_data && m_write;
        e_addr  = m_busy ? m_addr : 32'h0;
        e_store = (m_busy && m_data) ? m_store : 32'h0;
        hit     = m_busy && bus.ram_ready;
        chk("ramREN",   32'(bus.ramREN),   32'(e_ren));
        chk("ramWEN",   32'(bus.ramWEN),   32'(e_wen));
        chk("ramaddr",  bus.ramaddr,       e_addr);
        chk("ramstore", bus.ramstore,      e_store);
        chk("dhit",     32'(bus.dhit),     32'(hit && m_data));
        chk("ihit",     32'(bus.ihit),     32'(hit && !m_data));
        chk("dload",    bus.dload,         (hit && m_data) ? bus.ramload : 32'h0);
        chk("iload",    bus.iload,         (hit && !m_data) ? bus.ramload : 32'h0);
        chk("halted",   32'(bus.halted),   32'(m_halted));
        chk("err",      32'(bus.err),      32'(m_err));
        chk("hit_excl", 32'(bus.ihit & bus.dhit), 32'h0);
        @(posedge CLK);
        if (RST) begin
            model_reset();
        end else if (m_halted) begin
            // absorbing
        end else if (!m_busy) begin
            m_waited = 0;
            m_halt_flag = 0;
            if (bus.halt) begin
                m_halted = 1;
            end else if (bus.dREN || bus.dWEN) begin
                m_busy = 1; m_data = 1; m_addr = bus.daddr;
                m_store = bus.dstore; m_write = bus.dWEN;
            end else if (bus.iREN) begin
                m_busy = 1; m_data = 0; m_addr = bus.iaddr;
                m_store = '0; m_write = 0;
            end
        end else begin
            if (bus.halt) m_halt_flag = 1;
            if (bus.ram_ready || m_waited == int'(TO)) begin
                if (!bus.ram_ready) m_err = 1;
                m_busy = 0;
                if (m_halt_flag) m_halted = 1;
            end else begin
                m_waited++;
            end
        end
        #1;
    endtask

    task automatic clear_inputs();
        bus.halt = 0; bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ram_ready = 0;
    endtask

    initial begin
        bit slow;
        n_vec = 0;
        n_err = 0;
        RST = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        RST = 0;

        // Reset state
        #1;
        chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
        chk("rst_halted", 32'(bus.halted), 32'h0);
        chk("rst_err",    32'(bus.err),    32'h0);
        tick();

        // Instruction fetch, ready two cycles after grant
        bus.iREN = 1; bus.iaddr = 32'h40;
        tick();
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("if_wait_ren",  32'(bus.ramREN), 32'h1);
            chk("if_wait_addr", bus.ramaddr,     32'h40);
            chk("if_wait_ihit", 32'(bus.ihit),   32'h0);
            tick();
        end
        bus.ram_ready = 1; bus.ramload = 32'h8C220004;
        #1;
        chk("if_ihit",  32'(bus.ihit), 32'h1);
        chk("if_iload", bus.iload,     32'h8C220004);
        tick();
        bus.iREN = 0; bus.ram_ready = 0;
        #1;
        chk("if_idle_ren", 32'(bus.ramREN), 32'h0);
        tick();

        // Simultaneous requests: data write first, one idle cycle, then fetch
        bus.iREN = 1; bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h100;
        bus.dstore = 32'hDEADBEEF; bus.ram_ready = 1; bus.ramload = 32'h0;
        tick();
        #1;
        chk("dw_wen",   32'(bus.ramWEN), 32'h1);
        chk("dw_ren",   32'(bus.ramREN), 32'h0);
        chk("dw_store", bus.ramstore,    32'hDEADBEEF);
        chk("dw_dhit",  32'(bus.dhit),   32'h1);
        tick();
        bus.dREN = 0; bus.dWEN = 0;
        #1;
        chk("gap_ren",  32'(bus.ramREN), 32'h0);
        chk("gap_ihit", 32'(bus.ihit),   32'h0);
        tick();
        #1;
        chk("if2_ihit", 32'(bus.ihit),  32'h1);
        chk("if2_addr", bus.ramaddr,    32'h40);
        tick();
        bus.iREN = 0; bus.ram_ready = 0;
        tick();

        // Timeout: 16 strobe cycles, no hit, sticky err
        bus.dREN = 1; bus.daddr = 32'h200;
        tick();
        bus.dREN = 0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_ren",  32'(bus.ramREN), 32'h1);
            chk("to_dhit", 32'(bus.dhit),   32'h0);
            tick();
        end
        #1;
        chk("to_idle_ren", 32'(bus.ramREN), 32'h0);
        chk("to_err",      32'(bus.err),    32'h1);
        tick();

        // Reset in the 2nd cycle of a data access with err set
        bus.dREN = 1; bus.daddr = 32'h300;
        tick();
        tick();
        RST = 1;
        #1;
        chk("rst_mid_dhit", 32'(bus.dhit), 32'h0);
        tick();
        RST = 0; bus.dREN = 0; bus.ram_ready = 1;
        #1;
        chk("rst_after_err", 32'(bus.err),    32'h0);
        chk("rst_after_ren", 32'(bus.ramREN), 32'h0);
        chk("rst_after_dhit", 32'(bus.dhit),  32'h0);
        tick();
        bus.ram_ready = 0;

        // Halt during a fetch that completes in its 4th cycle
        bus.iREN = 1; bus.iaddr = 32'h80;
        tick();
        tick();
        bus.halt = 1;
        tick();
        tick();
        bus.ram_ready = 1; bus.ramload = 32'h12345678;
        #1;
        chk("halt_ihit", 32'(bus.ihit), 32'h1);
        tick();
        bus.ram_ready = 0; bus.halt = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("halted_flag", 32'(bus.halted), 32'h1);
            chk("halted_ren",  32'(bus.ramREN), 32'h0);
            tick();
        end
        RST = 1;
        tick();
        RST = 0;
        clear_inputs();

        // Randomized traffic
        slow = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) slow = ($urandom_range(0, 1) == 1);
            RST           = ($urandom_range(0, 99) == 0) || (m_halted && $urandom_range(0, 5) == 0);
            bus.halt      = ($urandom_range(0, 79) == 0);
            bus.iREN      = ($urandom_range(0, 1) == 1);
            bus.iaddr     = $urandom;
            bus.dREN      = ($urandom_range(0, 3) == 0);
            bus.dWEN      = ($urandom_range(0, 3) == 0);
            bus.daddr     = $urandom;
            bus.dstore    = $urandom;
            bus.ramload   = $urandom;
            bus.ram_ready = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of wait cycles per RAM access before abort (range 1..255).
REQ-002 SHALL have port CLK  in  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RST  in  1  synchronous, active-high reset.
REQ-004 SHALL have port halt  in  1  CPU halt request (level).
REQ-005 SHALL have ports iREN  in  1, and iaddr  in  32: the instruction fetch request and its word address.
REQ-006 SHALL have ports dREN  in  1, dWEN  in  1, daddr  in  32, and dstore  in  32: the data read request, data write request, data address and write data.
REQ-007 SHALL have ports ihit  out  1, and iload  out  32: the instruction access-complete strobe and the fetched word.
REQ-008 SHALL have ports dhit  out  1, and dload  out  32: the data access-complete strobe and the loaded word.
REQ-009 SHALL have ports ramREN  out  1, ramWEN  out  1, ramaddr  out  32, and ramstore  out  32: the single shared RAM port.
REQ-010 SHALL have ports ramload  in  32, and ram_ready  in  1: the RAM read data and the RAM access-complete signal.
REQ-011 SHALL have ports halted  out  1 (arbiter stopped) and err  out  1 (sticky RAM timeout flag).

Function
REQ-012 SHALL implement states IDLE, DACC, IACC and HALTED.
REQ-013 In IDLE at a clock edge, SHALL transition as follows, in priority order: halt=1 -> HALTED; dREN|dWEN -> DACC; iREN -> IACC; otherwise stay in IDLE.
REQ-014 Data SHALL have fixed priority over instruction when both request in the same IDLE cycle.
REQ-015 On entry to DACC/IACC, SHALL latch the address, the store data and the op (write if dWEN=1, so dWEN wins over dREN), and SHALL clear the wait counter.
REQ-016 In DACC, SHALL drive from the latched values: ramaddr, ramstore, ramWEN = latched write, and ramREN = !latched write.
REQ-017 In IACC, SHALL drive ramaddr = latched iaddr, ramREN=1, ramWEN=0.
REQ-018 In IDLE and HALTED, SHALL drive ramREN=ramWEN=0, ramaddr=0, ramstore=0.
REQ-019 When ram_ready=1 in DACC, SHALL drive dhit=1 and dload=ramload combinationally in that cycle, then go to IDLE at the next edge.
REQ-020 When ram_ready=1 in IACC, SHALL drive ihit=1 and iload=ramload combinationally in that cycle, then go to IDLE at the next edge.
REQ-021 Minimum latency SHALL be: request seen at edge N, hit possible in cycle N+1.
REQ-022 SHALL have a one IDLE cycle between consecutive accesses.
REQ-023 In any state other than a completing DACC, dhit SHALL be 0; in any state other than a completing IACC, ihit SHALL be 0; ihit and dhit SHALL never be 1 together.
REQ-024 dload/iload SHALL be 0 when the corresponding hit is 0.
REQ-025 Wait counter, width ceil(log2(TIMEOUT+1)), SHALL increment each DACC/IACC cycle with ram_ready=0.
REQ-026 If the counter equals TIMEOUT and ram_ready=0, SHALL abort: no hit, err set to 1, next state IDLE.
REQ-027 ram_ready=1 in the cycle the counter equals TIMEOUT SHALL count as a normal completion.
REQ-028 err SHALL be sticky until RST.
REQ-029 halt=1 during DACC/IACC SHALL NOT abort the access: the access completes or times out, then the next state is HALTED instead of IDLE.
REQ-030 HALTED SHALL be absorbing until RST; halted=1 only in HALTED; no requests are granted in HALTED.
REQ-031 Requesters SHALL hold request, address and data until the hit; changes mid-access SHALL be ignored because the values are latched.

Reset
REQ-032 RST=1 at an edge SHALL force state IDLE, wait counter 0, err 0, and latched registers 0, with priority over all other inputs.
REQ-033 After reset, SHALL drive ihit=dhit=0, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0, halted=0.
REQ-034 RST asserted mid-access SHALL drop the access with no hit, and RAM strobes SHALL be low from the cycle after that edge.

Verification
REQ-035 Scenario: iREN=1, iaddr=0x40, ram_ready high 2 cycles after grant, ramload=0x8C220004 -> ramREN=1 with ramaddr=0x40 for 3 cycles; ihit=1 and iload=0x8C220004 on the 3rd; IDLE next.
REQ-036 Scenario: iREN=dREN=dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ram_ready=1 immediately -> DACC first with ramWEN=1, ramREN=0, ramstore=0xDEADBEEF, dhit; then one IDLE cycle, then IACC.
REQ-037 Scenario: TIMEOUT=15, dREN=1, ram_ready held 0 -> strobes high for 16 cycles, no dhit, err=1 thereafter, then IDLE.
REQ-038 Scenario: halt=1 asserted in the 2nd cycle of an IACC that completes in its 4th cycle -> ihit in the 4th cycle, then HALTED, halted=1, subsequent iREN ignored.
REQ-039 Scenario: RST=1 in the 2nd cycle of a DACC with err=1 -> after the edge all outputs are at reset values, err=0, and no dhit is ever produced.
